// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply / restoring-divide unit with a single-cycle
// register-file writeback request at the end of each operation.
module mul_div_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic [1:0]        dbg_state
);

  // Handshake: start is taken on a rising edge when state is IDLE or DONE
  // and flush is low; busy stays high until the 32nd iteration retires and
  // done/wb_en pulse for exactly the one DONE cycle that follows.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  state_t              state;
  logic [5:0]          cnt;
  logic [1:0]          op_q;
  logic [REG_AW-1:0]   rd_q;
  logic [XLEN-1:0]     b_q;
  logic [XLEN:0]       hi_q;   // multiply high half / divide partial remainder
  logic [XLEN-1:0]     lo_q;   // multiply low half / divide quotient

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       mul_hi_n;
  logic [XLEN-1:0]     mul_lo_n;
  logic [XLEN:0]       div_rs;
  logic [XLEN+1:0]     div_diff;
  logic                div_ok;
  logic [XLEN:0]       div_hi_n;
  logic [XLEN-1:0]     div_lo_n;
  logic [XLEN:0]       hi_n;
  logic [XLEN-1:0]     lo_n;
  logic [XLEN-1:0]     result_n;
  logic [XLEN-1:0]     div0_result;
  logic                accept;

  always_comb begin
    mul_sum  = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_n = {1'b0, mul_sum[XLEN:1]};
    mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};

    // Remainder is always below the divisor, so its top bit is never set.
    div_rs   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff = {1'b0, div_rs} - {2'b00, b_q};
    div_ok   = ~div_diff[XLEN+1];
    div_hi_n = div_ok ? div_diff[XLEN:0] : div_rs;
    div_lo_n = {lo_q[XLEN-2:0], div_ok};

    hi_n = op_q[1] ? div_hi_n : mul_hi_n;
    lo_n = op_q[1] ? div_lo_n : mul_lo_n;

    case (op_q)
      OP_MUL:   result_n = mul_lo_n;
      OP_MULHU: result_n = mul_sum[XLEN:1];
      OP_DIVU:  result_n = div_lo_n;
      default:  result_n = div_hi_n[XLEN-1:0];
    endcase

    div0_result = op[0] ? src_a : '1;
    accept      = start && !flush && (state != RUN);
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          RUN: begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state   <= DONE;
              done    <= 1'b1;
              wb_en   <= |rd_q;
              wb_addr <= rd_q;
              wb_data <= result_n;
            end
          end
          default: begin
            if (accept) begin
              op_q <= op;
              rd_q <= rd_in;
              b_q  <= src_b;
              hi_q <= '0;
              lo_q <= src_a;
              cnt  <= '0;
              if (op[1] && (src_b == '0)) begin
                state   <= DONE;
                done    <= 1'b1;
                wb_en   <= |rd_in;
                wb_addr <= rd_in;
                wb_data <= div0_result;
              end else begin
                state <= RUN;
              end
            end else begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
